// File: rtl/pixel_uart_tx_if.sv
// ---------------------------------------------------------------------------
// pixel_uart_tx_if
// Pixel stream handshake between a producer and pixel_uart_tx.
//   valid : producer has a pixel on 'pixel'
//   pixel : 8-bit pixel byte
//   ready : consumer can take a pixel this cycle
// A beat transfers on a rising clock edge where valid && ready.
// ---------------------------------------------------------------------------
interface pixel_uart_tx_if;
    logic       valid;
    logic [7:0] pixel;
    logic       ready;

    modport master (output valid, output pixel, input ready);
    modport slave  (input valid, input pixel, output ready);
endinterface

// File: rtl/pixel_uart_tx.sv
// ---------------------------------------------------------------------------
// pixel_uart_tx
// Buffers pixels from a valid/ready stream in a small FIFO and sends each one
// as an 8N1 UART frame (start 0, 8 data bits LSB first, stop 1), with CLK_DIV
// clock cycles per bit. Frames for queued bytes follow each other with no
// idle gap.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   in_if      : pixel stream input (slave side: valid, pixel in, ready out)
//   ser_tx     : registered serial output, idles high
//   busy       : a frame is in progress or the FIFO holds data
//   fifo_count : number of pixels held in the FIFO
// ---------------------------------------------------------------------------
module pixel_uart_tx #(
    parameter int CLK_DIV    = 100,
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_uart_tx_if.slave       in_if,
    output logic                 ser_tx,
    output logic                 busy,
    output logic [CW-1:0]        fifo_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CDW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;

    state_t         state;
    state_t         state_next;
    logic [7:0]     shift_reg;
    logic [7:0]     shift_next;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_next;
    logic [CDW-1:0] cyc_cnt;
    logic [CDW-1:0] cyc_next;
    logic           ser_tx_next;
    logic           bit_end;

    assign push    = in_if.valid && in_if.ready;
    assign bit_end = (cyc_cnt == CDW'(CLK_DIV - 1));

    // FIFO storage is not reset: resetting the pointers and count is enough
    // to discard whatever it held.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_if.pixel;
        end
    end

    // State register plus FIFO pointers/count. ser_tx is registered from the
    // next-state values so it changes exactly with the state and never
    // glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            cyc_cnt    <= '0;
            ser_tx     <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_next;
            cyc_cnt   <= cyc_next;
            ser_tx    <= ser_tx_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Next-state logic. A pop is only issued when the FIFO is non-empty, and
    // the end of STOP pops straight into START so queued frames are
    // contiguous.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        bit_next   = bit_idx;
        cyc_next   = cyc_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    cyc_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_cnt + CDW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cyc_next = cyc_cnt + CDW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_next = '0;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cyc_next = cyc_cnt + CDW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: line level for the upcoming cycle, handshake and status.
    always_comb begin
        ser_tx_next = 1'b1;
        case (state_next)
            START:   ser_tx_next = 1'b0;
            DATA:    ser_tx_next = shift_next[0];
            default: ser_tx_next = 1'b1;
        endcase
        in_if.ready = (fifo_count != CW'(FIFO_DEPTH));
        busy        = (state != IDLE) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_pixel_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_pixel_uart_tx
// Self-checking bench for pixel_uart_tx. Accepted beats are pushed to a
// scoreboard queue; a serial monitor decodes every frame on ser_tx and
// compares it against the queue head. A table of single-byte vectors checks
// exact line levels bit by bit; hand-written sequences cover back-to-back
// frames, a full FIFO, push/pop on the same edge and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_pixel_uart_tx;

    localparam int CLK_DIV    = 100;
    localparam int FIFO_DEPTH = 16;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int FRAME      = 10 * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          ser_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    pixel_uart_tx_if bus ();

    pixel_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus.slave),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         n_cmp     = 0;
    int         n_err     = 0;
    int         cyc       = 0;
    int         max_count = 0;
    logic [7:0] exp_q [$];
    int         start_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0 && int'(fifo_count) > max_count) begin
            max_count = int'(fifo_count);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; holds valid until ready is seen, then returns at
    // the negedge after the transferring edge.
    task automatic apply_stimulus(input logic [7:0] b, input int limit, output int waits);
        waits     = 0;
        bus.valid = 1'b1;
        bus.pixel = b;
        while (bus.ready !== 1'b1 && waits < limit) begin
            @(negedge clk);
            waits++;
        end
        if (bus.ready === 1'b1) begin
            exp_q.push_back(b);
            @(negedge clk);
        end else begin
            check_output("send_timeout", 32'd0, 32'd1);
        end
        bus.valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Serial monitor: samples each bit at its middle; frames cut by reset
    // are dropped.
    logic [9:0] mon_frame;
    logic [7:0] mon_exp;
    bit         mon_abort;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ser_tx === 1'b0) begin
                start_log.push_back(cyc);
                mon_abort = 1'b0;
                mon_frame = '0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k != 0) @(negedge clk);
                    if (rst !== 1'b0) mon_abort = 1'b1;
                    if (k % CLK_DIV == CLK_DIV / 2) mon_frame[k / CLK_DIV] = ser_tx;
                end
                if (!mon_abort) begin
                    if (exp_q.size() == 0) begin
                        check_output("frame_without_beat", {22'd0, mon_frame}, 32'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check_output("frame", {22'd0, mon_frame},
                                     {22'd0, 1'b1, mon_exp, 1'b0});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(200_000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [7:0] pixel;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];
    int   w;
    int   mism;
    int   e0;
    int   idle_cyc;
    int   first_stall;
    int   quiet_bad;

    initial begin : main
        vecs[0] = '{8'h55, 10'b1_01010101_0};
        vecs[1] = '{8'hA5, 10'b1_10100101_0};
        vecs[2] = '{8'h00, 10'b1_00000000_0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0};
        vecs[4] = '{8'h01, 10'b1_00000001_0};

        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.pixel = 8'h00;
        repeat (3) @(negedge clk);
        check_output("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_count", 32'(fifo_count), 32'd0);
        check_output("rst_ready", {31'd0, bus.ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte frames checked level by level.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].pixel, 10, w);
            check_output($sformatf("tbl%0d_count_accept", i), 32'(fifo_count), 32'd1);
            check_output($sformatf("tbl%0d_idle_line", i), {31'd0, ser_tx}, 32'd1);
            mism = 0;
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge clk);
                if (ser_tx !== vecs[i].frame[(k - 1) / CLK_DIV]) mism++;
                if ((k - 1) % CLK_DIV == CLK_DIV / 2) begin
                    check_output($sformatf("tbl%0d_bit%0d", i, (k - 1) / CLK_DIV),
                                 {31'd0, ser_tx}, {31'd0, vecs[i].frame[(k - 1) / CLK_DIV]});
                end
                if (k == 1) begin
                    check_output($sformatf("tbl%0d_count_popped", i), 32'(fifo_count), 32'd0);
                end
            end
            check_output($sformatf("tbl%0d_shape", i), 32'(mism), 32'd0);
            check_output($sformatf("tbl%0d_busy_last", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
            check_output($sformatf("tbl%0d_busy_done", i), {31'd0, busy}, 32'd0);
            check_output($sformatf("tbl%0d_line_done", i), {31'd0, ser_tx}, 32'd1);
        end

        // Back-to-back: three contiguous frames.
        start_log.delete();
        apply_stimulus(8'h00, 10, w);
        apply_stimulus(8'hFF, 10, w);
        apply_stimulus(8'h41, 10, w);
        wait_idle("b2b", 4 * FRAME);
        idle_cyc = cyc;
        check_output("b2b_frames", 32'(start_log.size()), 32'd3);
        if (start_log.size() == 3) begin
            check_output("b2b_gap01", 32'(start_log[1] - start_log[0]), 32'(FRAME));
            check_output("b2b_gap12", 32'(start_log[2] - start_log[1]), 32'(FRAME));
            check_output("b2b_total", 32'(idle_cyc - start_log[0]), 32'(3 * FRAME));
        end
        check_output("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Full FIFO with valid held high for 20 bytes.
        max_count   = 0;
        first_stall = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == 17) begin
                check_output("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
                check_output("full_ready", {31'd0, bus.ready}, 32'd0);
            end
            apply_stimulus(8'(i), 3 * FRAME, w);
            if (w > 0 && first_stall < 0) first_stall = i;
        end
        wait_idle("full", 25 * FRAME);
        check_output("full_first_stall", 32'(first_stall), 32'd17);
        check_output("full_max_count", 32'(max_count), 32'(FIFO_DEPTH));
        check_output("full_drained", 32'(exp_q.size()), 32'd0);

        // Push on the same edge that ends STOP and pops.
        apply_stimulus(8'h61, 10, w);
        e0 = cyc;
        apply_stimulus(8'h62, 10, w);
        apply_stimulus(8'h63, 10, w);
        apply_stimulus(8'h64, 10, w);
        check_output("pp_count_before", 32'(fifo_count), 32'd3);
        while (cyc < e0 + FRAME) @(negedge clk);
        check_output("pp_count_stop", 32'(fifo_count), 32'd3);
        check_output("pp_line_stop", {31'd0, ser_tx}, 32'd1);
        apply_stimulus(8'h65, 10, w);
        check_output("pp_count_after", 32'(fifo_count), 32'd3);
        check_output("pp_line_start", {31'd0, ser_tx}, 32'd0);
        wait_idle("pp", 6 * FRAME);
        check_output("pp_drained", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 of 0xA5 with five bytes queued.
        apply_stimulus(8'hA5, 10, w);
        e0 = cyc;
        for (int i = 1; i <= 5; i++) apply_stimulus(8'(8'h10 + i), 10, w);
        check_output("rm_count_queued", 32'(fifo_count), 32'd5);
        while (cyc < e0 + 1 + 5 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
        check_output("rm_bit4", {31'd0, ser_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_output("rm_ser_tx", {31'd0, ser_tx}, 32'd1);
        check_output("rm_count", 32'(fifo_count), 32'd0);
        check_output("rm_ready", {31'd0, bus.ready}, 32'd1);
        check_output("rm_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        quiet_bad = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
        end
        check_output("rm_quiet", 32'(quiet_bad), 32'd0);
        apply_stimulus(8'h3C, 10, w);
        wait_idle("rm_after", 2 * FRAME);
        check_output("rm_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
